program_counter_stack: RTL and testbench
========================================

// Module: program_counter_stack
// PURPOSE
//  Next-generation CPU program counter: width-parametrised PC with increment, absolute jump,
//  relative jump and a hardware return-address stack for CALL/RET. Sits in the CPU core between
//  the decoder (drives op/dataIn) and the fetch path (consumes dataOut).
//  Removes the need for the microcode to spill return addresses to memory for nested calls.
// PARAMETERS
//  WIDTH         16   PC and address width in bits
//  DEPTH         8    return-stack entries (power of two, >=2)
//  REL_W         8    low dataIn bits used as the signed relative offset
//  REL_BIAS      -1   signed constant added on relative jumps (matches the CPU's prefetched PC)
//  RESET_VECTOR  0    PC value after reset
// PORTS
//  clk         in   1                  clock, all state on rising edge
//  reset       in   1                  asynchronous, active-low; clears all state
//  op          in   3                  000 HOLD, 001 INC, 010 JABS, 011 JREL, 100 CALL, 101 RET, 110 CALLR, 111 HOLD
//  dataIn      in   WIDTH              jump target (JABS/CALL) or offset source (JREL/CALLR)
//  dataOut     out  WIDTH              current PC
//  stackTop    out  WIDTH              entry at top of stack; 0 when empty
//  stackLevel  out  $clog2(DEPTH)+1    number of valid entries
//  stackFull   out  1                  stackLevel == DEPTH
//  stackEmpty  out  1                  stackLevel == 0
//  overflow    out  1                  sticky: CALL/CALLR issued while full
//  underflow   out  1                  sticky: RET issued while empty
//  errClear    in   1                  clears overflow/underflow next edge
// BEHAVIOUR
//  - Reset (reset=0, async): PC=RESET_VECTOR, stackLevel=0, stack RAM contents don't-care,
//    stackTop=0, stackEmpty=1, stackFull=0, overflow=0, underflow=0. Release takes effect next edge.
//  - One op per cycle, sampled on rising edge; dataOut/stack outputs update on that edge (1-cycle latency).
//  - INC: PC <= PC+1 mod 2^WIDTH (FFFF->0000 at WIDTH=16, no flag).
//  - JABS: PC <= dataIn.
//  - JREL: PC <= PC + sext(dataIn[REL_W-1:0]) + REL_BIAS, mod 2^WIDTH, wraps both directions.
//  - CALL: push current PC, PC <= dataIn. CALLR: push current PC, PC <= JREL target.
//  - RET: PC <= stackTop, pop.
//  - Stack: LIFO, registered level pointer; push writes slot[level], pop reads slot[level-1];
//    stackTop always reflects slot[level-1] combinationally from registered state.
//  - CALL then RET on consecutive cycles must return the pushed PC (no bubble).
//  - CALL/CALLR while full (macro off): jump still performed, push discarded, level unchanged,
//    overflow set.
//  - RET while empty: PC unchanged, level stays 0, underflow set.
//  - Sticky flags: set has priority over errClear in the same cycle.
//  - HOLD and op=111: no state change.
// CONFIGURATION
//  PC_STACK_WRAP_EN defined: stack is circular; CALL when full overwrites the oldest entry, level
//    stays DEPTH, overflow tied 0. RET-while-empty handling unchanged.
//  Not defined: saturating stack as described in BEHAVIOUR, overflow flag live.
// TESTING
//  1 Reset low mid-CALL with level=3 -> dataOut=RESET_VECTOR, level=0, flags 0, immediately (async).
//  2 PC=FFFF, INC -> 0000; PC=0010, JREL dataIn[7:0]=F0 -> 0010-16-1 = FFFF.
//  3 PC=0100 CALL 2000, PC=2000 CALL 3000, RET, RET -> PC 2000,3000,2000,0100; level 1,2,1,0.
//  4 DEPTH=8: 9 CALLs -> level 8, overflow=1, 9th target still taken; 8 RETs unwind the first 8 PCs
//    (macro on: overflow stays 0, 8 RETs return calls 9..2).
//  5 RET at level 0 -> PC unchanged, underflow=1; errClear=1 same cycle as new RET-empty -> stays 1.
//  6 CALLR PC=0050 dataIn=0005 -> PC=0054, stackTop=0050; RET next cycle -> PC=0050.

Source files
------------

// File: rtl/program_counter_stack.sv
// program_counter_stack: CPU program counter with increment, absolute/relative jump and a
// hardware return-address stack for CALL/RET.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low; clears PC, stack level and sticky flags
//   op          000 HOLD, 001 INC, 010 JABS, 011 JREL, 100 CALL, 101 RET, 110 CALLR, 111 HOLD
//   dataIn      jump target (JABS/CALL) or relative offset source (JREL/CALLR)
//   dataOut     current PC (registered)
//   stackTop    entry at top of stack, 0 when empty (decoded from registered state)
//   stackLevel  number of valid stack entries
//   stackFull   stackLevel == DEPTH
//   stackEmpty  stackLevel == 0
//   overflow    sticky: CALL/CALLR issued while full
//   underflow   sticky: RET issued while empty
//   errClear    clears overflow/underflow on the next edge (a new set wins)
//
// Build option
//   PC_STACK_WRAP_EN  circular stack: a push while full overwrites the oldest entry,
//                     level stays DEPTH and overflow is tied low.

module program_counter_stack #(
    parameter int unsigned          WIDTH        = 16,
    parameter int unsigned          DEPTH        = 8,
    parameter int unsigned          REL_W        = 8,
    parameter int                   REL_BIAS     = -1,
    parameter logic [WIDTH-1:0]     RESET_VECTOR = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               op,
    input  logic [WIDTH-1:0]         dataIn,
    input  logic                     errClear,
    output logic [WIDTH-1:0]         dataOut,
    output logic [WIDTH-1:0]         stackTop,
    output logic [$clog2(DEPTH):0]   stackLevel,
    output logic                     stackFull,
    output logic                     stackEmpty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned      AW        = $clog2(DEPTH);
    localparam int unsigned      LW        = AW + 1;
    localparam logic [LW-1:0]    LEVEL_MAX = LW'(DEPTH);
    localparam logic [WIDTH-1:0] BIAS      = WIDTH'(REL_BIAS);

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_INC   = 3'b001;
    localparam logic [2:0] OP_JABS  = 3'b010;
    localparam logic [2:0] OP_JREL  = 3'b011;
    localparam logic [2:0] OP_CALL  = 3'b100;
    localparam logic [2:0] OP_RET   = 3'b101;
    localparam logic [2:0] OP_CALLR = 3'b110;

    logic [WIDTH-1:0] stackMem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [WIDTH-1:0] relTarget;
    logic [WIDTH-1:0] pcNext;
    logic [LW-1:0]    levelNext;
    logic [AW-1:0]    wrPtrNext;
    logic             memWrite;
    logic             setOverflow;
    logic             setUnderflow;

    // Stack is addressed by a write pointer so the same logic serves both the
    // saturating build (wrPtr tracks level) and the circular build (wrPtr wraps).
    assign rdPtr      = wrPtr - AW'(1);
    assign stackEmpty = (stackLevel == '0);
    assign stackFull  = (stackLevel == LEVEL_MAX);
    assign stackTop   = stackEmpty ? '0 : stackMem[rdPtr];

    // Relative target: sign-extended low offset bits plus the prefetch bias, mod 2^WIDTH.
    assign relTarget = dataOut
                     + {{(WIDTH-REL_W){dataIn[REL_W-1]}}, dataIn[REL_W-1:0]}
                     + BIAS;

    // Next-state decode for PC, stack pointer/level and flag set conditions.
    always_comb begin
        pcNext       = dataOut;
        levelNext    = stackLevel;
        wrPtrNext    = wrPtr;
        memWrite     = 1'b0;
        setOverflow  = 1'b0;
        setUnderflow = 1'b0;

        case (op)
            OP_INC:  pcNext = dataOut + WIDTH'(1);
            OP_JABS: pcNext = dataIn;
            OP_JREL: pcNext = relTarget;
            OP_CALL, OP_CALLR: begin
                pcNext = (op == OP_CALL) ? dataIn : relTarget;
`ifdef PC_STACK_WRAP_EN
                memWrite  = 1'b1;
                wrPtrNext = wrPtr + AW'(1);
                levelNext = stackFull ? stackLevel : stackLevel + LW'(1);
`else
                if (stackFull) begin
                    setOverflow = 1'b1;
                end else begin
                    memWrite  = 1'b1;
                    wrPtrNext = wrPtr + AW'(1);
                    levelNext = stackLevel + LW'(1);
                end
`endif
            end
            OP_RET: begin
                if (stackEmpty) begin
                    setUnderflow = 1'b1;
                end else begin
                    pcNext    = stackTop;
                    wrPtrNext = rdPtr;
                    levelNext = stackLevel - LW'(1);
                end
            end
            default: pcNext = dataOut;
        endcase
    end

    // PC, stack pointer/level and sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dataOut    <= RESET_VECTOR;
            stackLevel <= '0;
            wrPtr      <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            dataOut    <= pcNext;
            stackLevel <= levelNext;
            wrPtr      <= wrPtrNext;
            overflow   <= setOverflow  | (overflow  & ~errClear);
            underflow  <= setUnderflow | (underflow & ~errClear);
        end
    end

    // Stack storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (memWrite) begin
            stackMem[wrPtr] <= dataOut;
        end
    end

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed testbench for program_counter_stack (default parameters).
module tb_program_counter_stack;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  op;
    logic [15:0] dataIn;
    logic        errClear;
    logic [15:0] dataOut;
    logic [15:0] stackTop;
    logic [3:0]  stackLevel;
    logic        stackFull;
    logic        stackEmpty;
    logic        overflow;
    logic        underflow;

    int errCount = 0;
    int chkCount = 0;

    localparam logic [2:0] HOLD = 3'b000, INC = 3'b001, JABS = 3'b010, JREL = 3'b011,
                           CALL = 3'b100, RET = 3'b101, CALLR = 3'b110, HOLD7 = 3'b111;

    program_counter_stack dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .dataIn     (dataIn),
        .errClear   (errClear),
        .dataOut    (dataOut),
        .stackTop   (stackTop),
        .stackLevel (stackLevel),
        .stackFull  (stackFull),
        .stackEmpty (stackEmpty),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one op on the falling edge, let it take effect, sample 1 time unit after the edge.
    task automatic doOp(input logic [2:0] o, input logic [15:0] d, input logic clr);
        @(negedge clk);
        op       = o;
        dataIn   = d;
        errClear = clr;
        @(posedge clk);
        #1;
        op       = HOLD;
        errClear = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        op       = HOLD;
        dataIn   = '0;
        errClear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_pc",    32'(dataOut), 32'h0000);
        checkVal("rst_level", 32'(stackLevel), 0);
        checkVal("rst_top",   32'(stackTop), 0);
        checkVal("rst_empty", 32'(stackEmpty), 1);
        checkVal("rst_full",  32'(stackFull), 0);
        checkVal("rst_flags", 32'({overflow, underflow}), 0);
        @(negedge clk);
        reset = 1'b1;

        // Increment wrap and relative jumps in both directions
        doOp(JABS, 16'hFFFF, 1'b0);
        doOp(INC,  16'h0000, 1'b0);
        checkVal("inc_wrap", 32'(dataOut), 32'h0000);
        doOp(INC,  16'h0000, 1'b0);
        checkVal("inc", 32'(dataOut), 32'h0001);
        doOp(JABS, 16'h0010, 1'b0);
        doOp(JREL, 16'h12F0, 1'b0);
        checkVal("jrel_neg_wrap", 32'(dataOut), 32'hFFFF);
        doOp(JREL, 16'h0005, 1'b0);
        checkVal("jrel_pos_wrap", 32'(dataOut), 32'h0003);
        doOp(JREL, 16'h007F, 1'b0);
        checkVal("jrel_max", 32'(dataOut), 32'h0081);

        // Nested CALL/RET
        doOp(JABS, 16'h0100, 1'b0);
        doOp(CALL, 16'h2000, 1'b0);
        checkVal("call1_pc",  32'(dataOut), 32'h2000);
        checkVal("call1_lvl", 32'(stackLevel), 1);
        checkVal("call1_top", 32'(stackTop), 32'h0100);
        doOp(CALL, 16'h3000, 1'b0);
        checkVal("call2_pc",  32'(dataOut), 32'h3000);
        checkVal("call2_lvl", 32'(stackLevel), 2);
        checkVal("call2_top", 32'(stackTop), 32'h2000);
        doOp(RET,  16'h0000, 1'b0);
        checkVal("ret1_pc",   32'(dataOut), 32'h2000);
        checkVal("ret1_lvl",  32'(stackLevel), 1);
        doOp(RET,  16'h0000, 1'b0);
        checkVal("ret2_pc",   32'(dataOut), 32'h0100);
        checkVal("ret2_lvl",  32'(stackLevel), 0);
        checkVal("ret2_empty", 32'(stackEmpty), 1);

        // CALLR then immediate RET
        doOp(JABS,  16'h0050, 1'b0);
        doOp(CALLR, 16'h0005, 1'b0);
        checkVal("callr_pc",  32'(dataOut), 32'h0054);
        checkVal("callr_top", 32'(stackTop), 32'h0050);
        doOp(RET,   16'h0000, 1'b0);
        checkVal("callr_ret", 32'(dataOut), 32'h0050);

        // Underflow, set-over-clear priority, then clear
        doOp(RET, 16'h0000, 1'b0);
        checkVal("udf_pc",  32'(dataOut), 32'h0050);
        checkVal("udf_lvl", 32'(stackLevel), 0);
        checkVal("udf_set", 32'(underflow), 1);
        doOp(RET, 16'h0000, 1'b1);
        checkVal("udf_set_wins", 32'(underflow), 1);
        doOp(HOLD, 16'h1234, 1'b1);
        checkVal("udf_clear", 32'(underflow), 0);

        // HOLD encodings leave state untouched
        doOp(HOLD7, 16'hABCD, 1'b0);
        checkVal("hold7_pc", 32'(dataOut), 32'h0050);

        // Fill past capacity: CALL k pushes PC k*0x100 and jumps to (k+1)*0x100
        doOp(JABS, 16'h0000, 1'b0);
        for (int k = 0; k < 9; k++) begin
            doOp(CALL, 16'((k + 1) * 16'h0100), 1'b0);
        end
        checkVal("fill_pc",   32'(dataOut), 32'h0900);
        checkVal("fill_lvl",  32'(stackLevel), 8);
        checkVal("fill_full", 32'(stackFull), 1);
`ifdef PC_STACK_WRAP_EN
        checkVal("fill_ovf",  32'(overflow), 0);
        for (int k = 8; k >= 1; k--) begin
            doOp(RET, 16'h0000, 1'b0);
            checkVal("unwind_pc", 32'(dataOut), 32'(k * 16'h0100));
        end
`else
        checkVal("fill_ovf",  32'(overflow), 1);
        for (int k = 7; k >= 0; k--) begin
            doOp(RET, 16'h0000, 1'b0);
            checkVal("unwind_pc", 32'(dataOut), 32'(k * 16'h0100));
        end
`endif
        checkVal("unwind_lvl", 32'(stackLevel), 0);

        // Async reset in the middle of a CALL with level 3 and flags set
        doOp(RET, 16'h0000, 1'b0);
        doOp(CALL, 16'h4000, 1'b0);
        doOp(CALL, 16'h5000, 1'b0);
        doOp(CALL, 16'h6000, 1'b0);
        checkVal("pre_rst_lvl", 32'(stackLevel), 3);
        @(negedge clk);
        op     = CALL;
        dataIn = 16'h7000;
        #2;
        reset = 1'b0;
        #1;
        checkVal("async_pc",    32'(dataOut), 32'h0000);
        checkVal("async_lvl",   32'(stackLevel), 0);
        checkVal("async_flags", 32'({overflow, underflow}), 0);
        checkVal("async_top",   32'(stackTop), 0);
        @(negedge clk);
        op    = HOLD;
        reset = 1'b1;
        doOp(CALL, 16'h0AAA, 1'b0);
        checkVal("post_rst_pc",  32'(dataOut), 32'h0AAA);
        checkVal("post_rst_top", 32'(stackTop), 32'h0000);
        checkVal("post_rst_lvl", 32'(stackLevel), 1);

        $display("Result: errors=%0d of %0d checks", errCount, chkCount);
        $finish;
    end

    // Guard against a stalled simulation.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errCount);
        $fatal(1, "timeout");
    end

endmodule
